// File: rtl/en_reg_fifo_if.sv
// Handshake bundle for en_reg_fifo: producer/consumer requests plus the
// head-of-queue data and status flags.
interface en_reg_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             flush;
    logic             wr_en;
    logic [WIDTH-1:0] D;
    logic             rd_en;
    logic [WIDTH-1:0] Q;
    logic             empty;
    logic             full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, wr_en, D, rd_en,
        input  Q, empty, full, count, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, D, rd_en,
        output Q, empty, full, count, overflow, underflow
    );
endinterface

// File: rtl/en_reg_fifo.sv
// DEPTH x WIDTH enable-register FIFO with show-ahead head data, occupancy
// count, full/empty flags, synchronous flush and registered error pulses.
module en_reg_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         CLRN,
    en_reg_fifo_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] we;
    logic             empty_w, full_w;
    logic             push, pop;

    // Wrap by compare so non-power-of-two depths never reach unused slots.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CW'(DEPTH));

    always_comb begin
        push = bus.wr_en && (!full_w || bus.rd_en) && !bus.flush;
        pop  = bus.rd_en && !empty_w && !bus.flush;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            ovf_d = bus.wr_en && full_w && !bus.rd_en;
            unf_d = bus.rd_en && empty_w;
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_comb begin
        we = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            we[i] = push && (wr_ptr_q == PW'(i));
        end
    end

    always_ff @(posedge clk or negedge CLRN) begin
        if (!CLRN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        always_ff @(posedge clk or negedge CLRN) begin
            if (!CLRN)      mem_q[g] <= '0;
            else if (we[g]) mem_q[g] <= bus.D;
        end
    end

    assign bus.Q         = empty_w ? '0 : mem_q[rd_ptr_q];
    assign bus.empty     = empty_w;
    assign bus.full      = full_w;
    assign bus.count     = count_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
endmodule

// File: tb/tb_en_reg_fifo.sv
// Bench for en_reg_fifo: an 8x4 and a 16x5 instance share stimulus and are
// compared every cycle against queue-based reference models.
module tb_en_reg_fifo;
    logic clk  = 1'b0;
    logic CLRN = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    en_reg_fifo_if #(.WIDTH(8),  .DEPTH(4)) if8 ();
    en_reg_fifo_if #(.WIDTH(16), .DEPTH(5)) if16 ();

    en_reg_fifo #(.WIDTH(8),  .DEPTH(4)) u8  (.clk(clk), .CLRN(CLRN), .bus(if8));
    en_reg_fifo #(.WIDTH(16), .DEPTH(5)) u16 (.clk(clk), .CLRN(CLRN), .bus(if16));

    logic [7:0]  m8  [$];
    logic [15:0] m16 [$];
    logic ov8 = 1'b0, un8 = 1'b0, ov16 = 1'b0, un16 = 1'b0;

    typedef struct {
        logic       f, w, r;
        logic [7:0] d;
        logic [7:0] q;
        logic [2:0] cnt;
        logic       e, fu, ov, un;
    } vec_t;
    vec_t tbl [$];

    function automatic vec_t mk(logic f, logic w, logic r, logic [7:0] d, logic [7:0] q,
                                logic [2:0] cnt, logic e, logic fu, logic ov, logic un);
        vec_t v;
        v.f = f; v.w = w; v.r = r; v.d = d; v.q = q;
        v.cnt = cnt; v.e = e; v.fu = fu; v.ov = ov; v.un = un;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_upd(input logic f, input logic w, input logic r, input logic [15:0] d);
        logic full8, full16, emp8, emp16;
        full8  = (m8.size() == 4);
        emp8   = (m8.size() == 0);
        full16 = (m16.size() == 5);
        emp16  = (m16.size() == 0);
        if (f) begin
            m8.delete(); m16.delete();
            ov8 = 0; un8 = 0; ov16 = 0; un16 = 0;
        end else begin
            ov8  = w && full8 && !r;
            un8  = r && emp8;
            ov16 = w && full16 && !r;
            un16 = r && emp16;
            if (r && !emp8)  void'(m8.pop_front());
            if (r && !emp16) void'(m16.pop_front());
            if (w && (!full8 || r))  m8.push_back(d[7:0]);
            if (w && (!full16 || r)) m16.push_back(d);
        end
    endtask

    task automatic check_all();
        chk("q8",      {24'h0, if8.Q},     {24'h0, (m8.size() != 0) ? m8[0] : 8'h00});
        chk("count8",  {29'h0, if8.count}, m8.size());
        chk("empty8",  {31'h0, if8.empty}, {31'h0, m8.size() == 0});
        chk("full8",   {31'h0, if8.full},  {31'h0, m8.size() == 4});
        chk("ovf8",    {31'h0, if8.overflow},  {31'h0, ov8});
        chk("unf8",    {31'h0, if8.underflow}, {31'h0, un8});
        chk("q16",     {16'h0, if16.Q},     {16'h0, (m16.size() != 0) ? m16[0] : 16'h0000});
        chk("count16", {29'h0, if16.count}, m16.size());
        chk("empty16", {31'h0, if16.empty}, {31'h0, m16.size() == 0});
        chk("full16",  {31'h0, if16.full},  {31'h0, m16.size() == 5});
        chk("ovf16",   {31'h0, if16.overflow},  {31'h0, ov16});
        chk("unf16",   {31'h0, if16.underflow}, {31'h0, un16});
    endtask

    task automatic drive(input logic f, input logic w, input logic r, input logic [15:0] d);
        if8.flush = f;  if8.wr_en = w;  if8.rd_en = r;  if8.D = d[7:0];
        if16.flush = f; if16.wr_en = w; if16.rd_en = r; if16.D = d;
    endtask

    task automatic step(input logic f, input logic w, input logic r, input logic [15:0] d);
        @(negedge clk);
        drive(f, w, r, d);
        @(posedge clk);
        model_upd(f, w, r, d);
        #1;
        check_all();
    endtask

    // Asynchronous reset pulse placed between edges, inputs idled first.
    task automatic do_reset();
        @(negedge clk);
        drive(0, 0, 0, 16'h0);
        #1 CLRN = 1'b0;
        #1;
        m8.delete(); m16.delete();
        ov8 = 0; un8 = 0; ov16 = 0; un16 = 0;
        check_all();
        #1 CLRN = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        drive(0, 0, 0, 16'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        CLRN = 1'b1;
        #1;
        check_all();

        step(0, 1, 0, 16'h0101);
        step(0, 1, 0, 16'h0202);
        step(0, 1, 0, 16'h0303);
        chk("pre_rst_count", {29'h0, if8.count}, 32'd3);
        do_reset();
        chk("rst_empty", {31'h0, if8.empty}, 32'd1);
        chk("rst_full",  {31'h0, if8.full},  32'd0);
        chk("rst_count", {29'h0, if8.count}, 32'd0);
        chk("rst_q",     {24'h0, if8.Q},     32'd0);
        step(0, 1, 0, 16'h12A5);
        chk("post_rst_q",     {24'h0, if8.Q},     32'hA5);
        chk("post_rst_count", {29'h0, if8.count}, 32'd1);

        //                 f  w  r  d      q     cnt e  fu ov un
        tbl.push_back(mk(1, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h11, 8'h11, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h22, 8'h11, 2, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h33, 8'h11, 3, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h44, 8'h11, 4, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h99, 8'h11, 4, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h11, 4, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 8'hAA, 8'h22, 4, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h33, 3, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h44, 2, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'hAA, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h00, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h00, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 8'hBB, 8'hBB, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 8'hCC, 8'hBB, 2, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 8'hDD, 8'h00, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'hEE, 8'hEE, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h00, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h01, 8'h01, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h02, 8'h01, 2, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h03, 8'h01, 3, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h02, 2, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h03, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h00, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h55, 8'h55, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h66, 8'h55, 2, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h77, 8'h55, 3, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h88, 8'h55, 4, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h66, 3, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h77, 2, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h88, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h00, 0, 1, 0, 0, 0));

        foreach (tbl[i]) begin
            step(tbl[i].f, tbl[i].w, tbl[i].r, {8'($urandom), tbl[i].d});
            chk($sformatf("tbl%0d_q", i),   {24'h0, if8.Q},        {24'h0, tbl[i].q});
            chk($sformatf("tbl%0d_cnt", i), {29'h0, if8.count},    {29'h0, tbl[i].cnt});
            chk($sformatf("tbl%0d_e", i),   {31'h0, if8.empty},    {31'h0, tbl[i].e});
            chk($sformatf("tbl%0d_f", i),   {31'h0, if8.full},     {31'h0, tbl[i].fu});
            chk($sformatf("tbl%0d_ov", i),  {31'h0, if8.overflow}, {31'h0, tbl[i].ov});
            chk($sformatf("tbl%0d_un", i),  {31'h0, if8.underflow},{31'h0, tbl[i].un});
        end

        // 16x5 fill/drain and non-power-of-two wrap.
        step(1, 0, 0, 16'h0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 16'h1000 + 16'(i));
        chk("full16_at5", {31'h0, if16.full}, 32'd1);
        chk("head16", {16'h0, if16.Q}, 32'h1000);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 16'h0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 16'h2000 + 16'(i));
        for (int i = 0; i < 3; i++) step(0, 0, 1, 16'h0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 16'h5500 + 16'(i));
        chk("wrap16_head", {16'h0, if16.Q}, 32'h5500);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 16'h0);
        chk("wrap16_empty", {31'h0, if16.empty}, 32'd1);

        for (int c = 0; c < 3000; c++) begin
            int unsigned wp;
            wp = (((c / 150) % 2) == 0) ? 75 : 35;
            if ($urandom_range(599) == 0) do_reset();
            step($urandom_range(39) == 0, $urandom_range(99) < wp,
                 $urandom_range(99) < (110 - wp), 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
